apb_req_master: RTL and testbench

APB_REQ_MASTER -- requirements
Module: apb_req_master

---
 rtl/apb_req_master.sv | 77 +++++++
 tb/tb_apb_req_master.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/apb_req_master.sv
// apb_req_master: single-outstanding request-port to APB master bridge with ACCESS wait timeout
module apb_req_master #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [2:0]  PPROT_VAL      = 3'b000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  inport_wr_i,
    input  logic        inport_rd_i,
    input  logic [31:0] inport_addr_i,
    input  logic [31:0] inport_write_data_i,
    output logic        inport_accept_o,
    output logic        inport_ack_o,
    output logic        inport_error_o,
    output logic [31:0] inport_read_data_o,
    output logic [31:0] out_paddr,
    output logic        out_psel,
    output logic        out_penable,
    output logic [2:0]  out_pprot,
    output logic        out_pwrite,
    output logic [31:0] out_pwdata,
    output logic [3:0]  out_pstrb,
    input  logic        out_pready,
    input  logic [31:0] out_prdata,
    input  logic        out_pslverr
);
    localparam int CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    state_t state, state_next;
    logic [CW-1:0] wait_cnt;
    logic take, is_wr, timeout;
    always_comb begin
        is_wr = |inport_wr_i;
        take = (state == IDLE) && (inport_rd_i || is_wr);
        timeout = (TIMEOUT_CYCLES != 0) && (32'(wait_cnt) + 32'd1 == TIMEOUT_CYCLES);
        state_next = state == IDLE   ? (take ? SETUP : IDLE) :
                     state == SETUP  ? ACCESS :
                     state == ACCESS ? ((out_pready || timeout) ? RESP : ACCESS) : IDLE;
        inport_accept_o = state == IDLE;
        inport_ack_o = state == RESP;
        out_psel = (state == SETUP) || (state == ACCESS);
        out_penable = state == ACCESS;
        out_pprot = PPROT_VAL;
    end
    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else state <= state_next;
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            out_paddr <= '0;
            out_pwrite <= 1'b0;
            out_pwdata <= '0;
            out_pstrb <= '0;
            wait_cnt <= '0;
            inport_error_o <= 1'b0;
            inport_read_data_o <= '0;
        end else begin
            if (take) begin
                out_paddr <= inport_addr_i;
                out_pwrite <= is_wr;
                out_pwdata <= is_wr ? inport_write_data_i : '0;
                out_pstrb <= is_wr ? inport_wr_i : '0;
            end
            if (state == SETUP) wait_cnt <= '0;
            else if (state == ACCESS && !out_pready) wait_cnt <= wait_cnt + CW'(1);
            // pready wins over a timeout reached in the same cycle
            if (state == ACCESS && out_pready) begin
                inport_error_o <= out_pslverr;
                if (!out_pwrite) inport_read_data_o <= out_prdata;
            end else if (state == ACCESS && timeout) begin
                inport_error_o <= 1'b1;
                if (!out_pwrite) inport_read_data_o <= '0;
            end
        end
    end
endmodule

// File: tb/tb_apb_req_master.sv
// tb_apb_req_master: randomized transaction checks against a transaction-level model
module tb_apb_req_master;
    localparam int TMO = 4;
    localparam logic [2:0] PROT = 3'b101;
    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  wr;
    logic        rd;
    logic [31:0] addr, wdata;
    logic        accept, ack, error;
    logic [31:0] read_data;
    logic [31:0] paddr, pwdata, prdata;
    logic        psel, penable, pwrite, pready, pslverr;
    logic [2:0]  pprot;
    logic [3:0]  pstrb;
    int n_chk = 0;
    int n_err = 0;
    logic [31:0] exp_rdata;

    apb_req_master #(.TIMEOUT_CYCLES(TMO), .PPROT_VAL(PROT)) dut (
        .clock(clock), .reset(reset),
        .inport_wr_i(wr), .inport_rd_i(rd), .inport_addr_i(addr), .inport_write_data_i(wdata),
        .inport_accept_o(accept), .inport_ack_o(ack), .inport_error_o(error),
        .inport_read_data_o(read_data),
        .out_paddr(paddr), .out_psel(psel), .out_penable(penable), .out_pprot(pprot),
        .out_pwrite(pwrite), .out_pwdata(pwdata), .out_pstrb(pstrb),
        .out_pready(pready), .out_prdata(prdata), .out_pslverr(pslverr)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // One full transaction from an IDLE negedge; expectations come from the protocol rules:
    // waits >= TMO times out after TMO ACCESS cycles, otherwise completes after waits+1.
    task automatic do_txn(input logic rd_in, input logic [3:0] wr_in, input logic [31:0] a,
                          input logic [31:0] d, input int waits, input logic serr,
                          input logic [31:0] rdat);
        logic w, to, e_err;
        logic [3:0] e_strb;
        logic [31:0] e_wdata;
        int n_acc;
        w = wr_in != 4'h0;
        e_strb = w ? wr_in : 4'h0;
        e_wdata = w ? d : 32'h0;
        to = waits >= TMO;
        n_acc = to ? TMO : waits + 1;
        e_err = to ? 1'b1 : serr;
        if (!w) exp_rdata = to ? 32'h0 : rdat;
        n_chk++;
        if (accept !== 1'b1) begin n_err++; $display("FAIL idle_accept: got %b want 1", accept); end
        rd = rd_in; wr = wr_in; addr = a; wdata = d; pready = 1'b0;
        @(negedge clock);
        rd = 1'($urandom); wr = 4'($urandom); addr = $urandom; wdata = $urandom;
        n_chk++;
        if ({psel, penable, accept} !== 3'b100) begin
            n_err++; $display("FAIL setup_ctl: got psel/pen/acc=%b want 100", {psel, penable, accept});
        end
        n_chk++;
        if ({paddr, pwrite, pstrb, pwdata} !== {a, w, e_strb, e_wdata}) begin
            n_err++; $display("FAIL setup_req: got %h %b %h %h want %h %b %h %h",
                              paddr, pwrite, pstrb, pwdata, a, w, e_strb, e_wdata);
        end
        for (int k = 0; k < n_acc; k++) begin
            @(negedge clock);
            n_chk++;
            if ({psel, penable, ack, accept} !== 4'b1100) begin
                n_err++; $display("FAIL access_ctl[%0d]: got psel/pen/ack/acc=%b want 1100", k,
                                  {psel, penable, ack, accept});
            end
            n_chk++;
            if ({paddr, pwrite, pstrb, pwdata} !== {a, w, e_strb, e_wdata}) begin
                n_err++; $display("FAIL access_stable[%0d]: got %h %b %h %h want %h %b %h %h", k,
                                  paddr, pwrite, pstrb, pwdata, a, w, e_strb, e_wdata);
            end
            pready = (k == waits);
            prdata = (k == waits) ? rdat : $urandom;
            pslverr = (k == waits) ? serr : 1'($urandom);
        end
        @(negedge clock);
        pready = 1'b0; rd = 1'b0; wr = 4'h0;
        n_chk++;
        if ({ack, psel, penable, accept} !== 4'b1000) begin
            n_err++; $display("FAIL resp_ctl: got ack/psel/pen/acc=%b want 1000", {ack, psel, penable, accept});
        end
        n_chk++;
        if (error !== e_err) begin n_err++; $display("FAIL resp_error: got %b want %b", error, e_err); end
        n_chk++;
        if (read_data !== exp_rdata) begin
            n_err++; $display("FAIL resp_rdata: got %h want %h", read_data, exp_rdata);
        end
        @(negedge clock);
        n_chk++;
        if ({ack, accept, psel} !== 3'b010) begin
            n_err++; $display("FAIL post_idle: got ack/acc/psel=%b want 010", {ack, accept, psel});
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; rd = 1'b0; wr = 4'h0; addr = 32'h0; wdata = 32'h0;
        pready = 1'b0; prdata = 32'h0; pslverr = 1'b0;
        repeat (3) @(negedge clock);
        exp_rdata = 32'h0;
        n_chk++;
        if ({accept, ack, error, psel, penable, pwrite} !== 6'b100000) begin
            n_err++; $display("FAIL reset_ctl: got %b want 100000", {accept, ack, error, psel, penable, pwrite});
        end
        n_chk++;
        if ({paddr, pwdata, pstrb, read_data} !== 100'h0) begin
            n_err++; $display("FAIL reset_regs: got %h %h %h %h want 0", paddr, pwdata, pstrb, read_data);
        end
        n_chk++;
        if (pprot !== PROT) begin n_err++; $display("FAIL pprot: got %b want %b", pprot, PROT); end
        reset = 1'b1;
        @(negedge clock);
        n_chk++;
        if (accept !== 1'b1) begin n_err++; $display("FAIL reset_release: got %b want 1", accept); end
    endtask

    task automatic test_read_zero_wait;
        do_txn(1'b1, 4'h0, 32'h8000_0010, $urandom, 0, 1'b0, 32'hDEAD_BEEF);
    endtask

    task automatic test_write_waits;
        do_txn(1'b0, 4'b0011, 32'h0000_1000, 32'h1234_5678, 3, 1'b0, $urandom);
    endtask

    task automatic test_slave_error;
        do_txn(1'b1, 4'h0, 32'h0000_2004, 32'h0, 1, 1'b1, 32'hCAFE_F00D);
    endtask

    task automatic test_timeout;
        do_txn(1'b1, 4'h0, 32'h0000_3008, 32'h0, 20, 1'b0, 32'h5555_AAAA);
        do_txn(1'b0, 4'hC, 32'h0000_300C, 32'hA5A5_5A5A, TMO, 1'b0, 32'h0);
        do_txn(1'b1, 4'h0, 32'h0000_3010, 32'h0, TMO - 1, 1'b0, 32'h0BAD_CAFE);
    endtask

    task automatic test_rd_wr_collision;
        do_txn(1'b1, 4'hF, 32'h0000_4000, 32'hFEED_FACE, 0, 1'b0, 32'h1111_2222);
    endtask

    task automatic test_reset_mid;
        rd = 1'b1; addr = 32'h0000_5000;
        @(negedge clock);
        rd = 1'b0;
        @(negedge clock);
        n_chk++;
        if ({psel, penable} !== 2'b11) begin n_err++; $display("FAIL midrst_access: got %b want 11", {psel, penable}); end
        reset = 1'b0;
        @(negedge clock);
        exp_rdata = 32'h0;
        n_chk++;
        if ({psel, penable, ack} !== 3'b000) begin
            n_err++; $display("FAIL midrst_abort: got psel/pen/ack=%b want 000", {psel, penable, ack});
        end
        reset = 1'b1;
        @(negedge clock);
        n_chk++;
        if ({accept, ack} !== 2'b10) begin n_err++; $display("FAIL midrst_release: got acc/ack=%b want 10", {accept, ack}); end
        do_txn(1'b1, 4'h0, 32'h0000_5004, 32'h0, 2, 1'b0, 32'h7777_8888);
    endtask

    task automatic test_random;
        for (int i = 0; i < 60; i++) begin
            int kind;
            kind = $urandom_range(0, 2);
            do_txn(kind != 1, (kind == 0) ? 4'h0 : 4'($urandom_range(1, 15)), $urandom, $urandom,
                   $urandom_range(0, 6), 1'($urandom), $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_waits();
        test_slave_error();
        test_timeout();
        test_rd_wr_collision();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
